// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// capture into a small instruction buffer, redirect/halt flushing.
// Optional macro IFETCH_MISALIGN_CHK_EN adds the ERR state and the sticky
// misaligned-target flag; without it redirect targets are word-aligned.
module instr_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_misaligned
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

`ifdef IFETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {RUN, HALTED, ERR} state_t;
`else
    typedef enum logic [1:0] {RUN, HALTED} state_t;
`endif

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] aq_rd;
    logic [PW-1:0] aq_wr;
    logic [63:0]   fifo_mem [BUF_DEPTH];
    logic [31:0]   aq_mem   [BUF_DEPTH];

    logic          run;
    logic          pop;
    logic          accept;
    logic          rsp;
    logic          keep;
    logic          do_halt;
    logic          do_redir;
    logic [CW-1:0] out_next;
    logic [31:0]   redir_tgt;
    logic [63:0]   head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misaligned_q;
    logic redir_bad;
    assign o_misaligned = misaligned_q;
    // Keep the raw target so a misaligned redirect can be detected
    always_comb begin
        redir_tgt = i_redirect_pc;
        redir_bad = |i_redirect_pc[1:0];
    end
`else
    logic unused_redirect_lsb;
    assign o_misaligned        = 1'b0;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];
    // Force word alignment of the redirect target
    always_comb begin
        redir_tgt = {i_redirect_pc[31:2], 2'b00};
    end
`endif

    // Handshake decode and credit check; a same-cycle pop frees one credit
    always_comb begin
        run         = (state == RUN);
        o_valid     = run && (fifo_cnt != '0);
        pop         = o_valid && i_ready;
        o_imem_req  = i_rst && run &&
                      (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < (SW'(BUF_DEPTH) + SW'(pop)));
        o_imem_addr = fetch_pc;
        accept      = o_imem_req && i_imem_gnt;
        // Responses with nothing outstanding are stale (e.g. issued before reset)
        rsp         = i_imem_rvalid && (out_cnt != '0);
        do_halt     = run && i_halt;
        do_redir    = run && !i_halt && i_redirect;
        keep        = run && !i_halt && !i_redirect && rsp && (drop_cnt == '0);
        out_next    = out_cnt + CW'(accept) - CW'(rsp);
        head        = fifo_mem[fifo_rd];
        o_instr     = o_valid ? head[63:32] : 32'h0000_0013;
        o_pc        = o_valid ? head[31:0]  : 32'h0000_0000;
    end

    // State, fetch pointer, in-flight accounting, address queue and buffer
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state    <= RUN;
            fetch_pc <= RESET_ADDR;
            out_cnt  <= '0;
            drop_cnt <= '0;
            fifo_cnt <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            aq_rd    <= '0;
            aq_wr    <= '0;
`ifdef IFETCH_MISALIGN_CHK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            out_cnt <= out_next;
            if (do_halt) begin
                state    <= HALTED;
                drop_cnt <= '0;
                fifo_cnt <= '0;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
                aq_rd    <= '0;
                aq_wr    <= '0;
            end else if (do_redir) begin
                // Everything still in flight after this cycle belongs to the old path
                fetch_pc <= redir_tgt;
                drop_cnt <= out_next;
                fifo_cnt <= '0;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
                aq_rd    <= '0;
                aq_wr    <= '0;
`ifdef IFETCH_MISALIGN_CHK_EN
                if (redir_bad) begin
                    state        <= ERR;
                    misaligned_q <= 1'b1;
                end
`endif
            end else if (run) begin
                if (accept) begin
                    fetch_pc      <= fetch_pc + 32'd4;
                    aq_mem[aq_wr] <= fetch_pc;
                    aq_wr         <= ptr_inc(aq_wr);
                end
                if (rsp) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CW'(1);
                    end else begin
                        fifo_mem[fifo_wr] <= {i_imem_rdata, aq_mem[aq_rd]};
                        fifo_wr           <= ptr_inc(fifo_wr);
                        aq_rd             <= ptr_inc(aq_rd);
                    end
                end
                if (pop) begin
                    fifo_rd <= ptr_inc(fifo_rd);
                end
                fifo_cnt <= fifo_cnt + CW'(keep) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written
// sequences for misaligned redirect, reset mid-operation, halt and grant stall.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;

    instr_fetch #(.RESET_ADDR(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_gnt   (imem_gnt),
        .i_imem_rvalid(imem_rvalid),
        .i_imem_rdata (imem_rdata),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .i_halt       (halt),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_instr      (instr),
        .o_pc         (pc),
        .o_misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        logic        hlt;
        logic        rsp_en;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl [26];
    logic [31:0] q [$];
    int          total;
    int          bad;
    logic        gnt_en;
    logic        s_req;
    logic        s_valid;
    logic        s_mis;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    assign imem_gnt = gnt_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(input logic rdy, red, input logic [31:0] rpc,
                                input logic hlt, rsp_en, e_req, e_valid,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.red = red; v.rpc = rpc; v.hlt = hlt; v.rsp_en = rsp_en;
        v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, model memory
    task automatic step(input logic rdy, red, input logic [31:0] rpc,
                        input logic hlt, rsp_en);
        ready       = rdy;
        redirect    = red;
        redirect_pc = rpc;
        halt        = hlt;
        imem_rvalid = rsp_en && (q.size() > 0);
        imem_rdata  = (q.size() > 0) ? mem_word(q[0]) : 32'h0;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid;
        s_pc    = pc;
        s_instr = instr;
        s_mis   = misaligned;
        if (s_req && gnt_en) q.push_back(s_addr);
        @(posedge clk);
        if (imem_rvalid) void'(q.pop_front());
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; gnt_en = 1'b1;
        rst = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        tbl[0]  = mk(1,0,32'h0,0,1, 1,0,32'h0);
        tbl[1]  = mk(1,0,32'h0,0,1, 1,0,32'h0);
        tbl[2]  = mk(1,0,32'h0,0,1, 1,1,32'h0);
        tbl[3]  = mk(1,0,32'h0,0,1, 1,1,32'h4);
        tbl[4]  = mk(1,0,32'h0,0,1, 1,1,32'h8);
        tbl[5]  = mk(1,0,32'h0,0,1, 1,1,32'hC);
        for (int i = 6; i <= 10; i++) tbl[i] = mk(0,0,32'h0,0,1, 0,1,32'h10);
        tbl[11] = mk(1,0,32'h0,0,1, 1,1,32'h10);
        tbl[12] = mk(1,0,32'h0,0,1, 1,1,32'h14);
        tbl[13] = mk(1,0,32'h0,0,1, 1,1,32'h18);
        tbl[14] = mk(1,0,32'h0,0,1, 1,1,32'h1C);
        tbl[15] = mk(1,0,32'h0,0,0, 1,1,32'h20);
        tbl[16] = mk(1,1,32'h100,0,0, 0,0,32'h0);
        tbl[17] = mk(1,0,32'h0,0,1, 0,0,32'h0);
        tbl[18] = mk(1,0,32'h0,0,1, 1,0,32'h0);
        tbl[19] = mk(1,0,32'h0,0,1, 1,0,32'h0);
        tbl[20] = mk(1,0,32'h0,0,1, 1,1,32'h100);
        tbl[21] = mk(1,1,32'hFFFF_FFFC,0,1, 1,1,32'h104);
        tbl[22] = mk(1,0,32'h0,0,1, 1,0,32'h0);
        tbl[23] = mk(1,0,32'h0,0,1, 1,0,32'h0);
        tbl[24] = mk(1,0,32'h0,0,1, 1,1,32'hFFFF_FFFC);
        tbl[25] = mk(1,0,32'h0,0,1, 1,1,32'h0);

        @(posedge clk); #1;
        do_reset(3);
        chk("rst.req",   {31'b0, s_req},   32'h0);
        chk("rst.valid", {31'b0, s_valid}, 32'h0);
        chk("rst.instr", s_instr,          32'h13);
        chk("rst.pc",    s_pc,             32'h0);
        chk("rst.mis",   {31'b0, s_mis},   32'h0);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rdy, tbl[i].red, tbl[i].rpc, tbl[i].hlt, tbl[i].rsp_en);
            chk($sformatf("vec%0d.req", i),   {31'b0, s_req},   {31'b0, tbl[i].e_req});
            chk($sformatf("vec%0d.valid", i), {31'b0, s_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d.pc", i),    s_pc, tbl[i].e_valid ? tbl[i].e_pc : 32'h0);
            chk($sformatf("vec%0d.instr", i), s_instr,
                tbl[i].e_valid ? mem_word(tbl[i].e_pc) : 32'h13);
        end

        // Redirect to a non-word-aligned target
        q.delete();
        do_reset(2);
        step(1,0,32'h0,0,1);
        step(1,0,32'h0,0,1);
        step(1,1,32'h102,0,1);
        chk("mis.pc_before", s_pc, 32'h0);
        step(1,0,32'h0,0,1);
        chk("mis.valid", {31'b0, s_valid}, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("mis.flag", {31'b0, s_mis}, 32'h1);
        chk("mis.req",  {31'b0, s_req}, 32'h0);
        step(1,0,32'h0,0,1);
        step(1,0,32'h0,0,1);
        chk("mis.flag_hold", {31'b0, s_mis},   32'h1);
        chk("mis.req_hold",  {31'b0, s_req},   32'h0);
        chk("mis.valid_hold",{31'b0, s_valid}, 32'h0);
`else
        chk("mis.flag", {31'b0, s_mis}, 32'h0);
        chk("mis.req",  {31'b0, s_req}, 32'h1);
        chk("mis.addr", s_addr,         32'h100);
        step(1,0,32'h0,0,1);
        step(1,0,32'h0,0,1);
        chk("mis.valid_new", {31'b0, s_valid}, 32'h1);
        chk("mis.pc_new",    s_pc,             32'h100);
`endif

        // Reset with a response in flight, then halt
        q.delete();
        do_reset(2);
        step(1,0,32'h0,0,1);
        step(1,0,32'h0,0,1);
        rst = 1'b0;
        step(1,0,32'h0,0,0);
        step(1,0,32'h0,0,0);
        chk("midrst.valid", {31'b0, s_valid}, 32'h0);
        chk("midrst.req",   {31'b0, s_req},   32'h0);
        rst = 1'b1;
        step(1,0,32'h0,0,1);
        chk("post.req",  {31'b0, s_req}, 32'h1);
        chk("post.addr", s_addr,         32'h0);
        step(1,0,32'h0,0,1);
        step(1,0,32'h0,0,1);
        chk("post.valid", {31'b0, s_valid}, 32'h1);
        chk("post.pc",    s_pc,             32'h0);
        chk("post.instr", s_instr,          mem_word(32'h0));
        step(1,0,32'h0,1,1);
        chk("halt.pc_before", s_pc, 32'h4);
        for (int i = 0; i < 4; i++) begin
            step(1, (i == 1), 32'h200, 1'b0, 1'b1);
            chk($sformatf("halt%0d.req", i),   {31'b0, s_req},   32'h0);
            chk($sformatf("halt%0d.valid", i), {31'b0, s_valid}, 32'h0);
            chk($sformatf("halt%0d.instr", i), s_instr,          32'h13);
        end

        // Request address held while the grant is withheld
        q.delete();
        do_reset(2);
        gnt_en = 1'b0;
        step(1,0,32'h0,0,1);
        chk("stall0.req",  {31'b0, s_req}, 32'h1);
        chk("stall0.addr", s_addr,         32'h0);
        step(1,0,32'h0,0,1);
        chk("stall1.req",  {31'b0, s_req}, 32'h1);
        chk("stall1.addr", s_addr,         32'h0);
        gnt_en = 1'b1;
        step(1,0,32'h0,0,1);
        chk("stall2.addr", s_addr, 32'h0);
        step(1,0,32'h0,0,1);
        chk("stall3.addr", s_addr, 32'h4);
        step(1,0,32'h0,0,1);
        chk("stall4.valid", {31'b0, s_valid}, 32'h1);
        chk("stall4.pc",    s_pc,             32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
